// File: rtl/i2c_slave_responder_if.sv
// Bus-side and host-side signal bundle for the I2C target responder.
interface i2c_slave_responder_if;
   logic       scl_i;
   logic       sda_i;
   logic       sda_o;
   logic [7:0] tx_dat_i;
   logic       tx_vld_i;
   logic       tx_rdy_o;
   logic [7:0] rx_dat_o;
   logic       rx_vld_o;
   logic       start_o;
   logic       stop_o;
   logic       rw_o;
   logic       busy_o;
   logic       underflow_o;

   modport slave (
      input  scl_i, sda_i, tx_dat_i, tx_vld_i,
      output sda_o, tx_rdy_o, rx_dat_o, rx_vld_o, start_o, stop_o, rw_o, busy_o, underflow_o
   );

   modport master (
      output scl_i, sda_i, tx_dat_i, tx_vld_i,
      input  sda_o, tx_rdy_o, rx_dat_o, rx_vld_o, start_o, stop_o, rw_o, busy_o, underflow_o
   );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target: START/STOP detect, 7-bit address match, write-byte strobe and
// read bytes served from a TX FIFO, all sampled on the system clock.
module i2c_slave_responder #(
   parameter logic [6:0] SLAVE_ADDR = 7'h22,
   parameter int         TX_DEPTH   = 8,
   parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   i2c_slave_responder_if.slave bus
);
   localparam int AW = $clog2(TX_DEPTH);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
   } state_t;

   state_t     r_state, w_state;
   logic [2:0] r_scl_q, r_sda_q;
   logic       w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

   logic [3:0] r_cnt, w_cnt;
   logic [6:0] r_sh, w_sh;
   logic [7:0] r_tx_sh, w_tx_sh;
   logic [7:0] r_rx_dat, w_rx_dat;
   logic       r_sda, w_sda_o;
   logic       r_rw, w_rw, r_busy, w_busy;
   logic       r_rx_vld, w_rx_vld, r_start_o, w_start_o, r_stop_o, w_stop_o, r_unf, w_unf;

   logic [7:0]    r_mem [TX_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_fcnt, w_fcnt_nxt;
   logic          r_tx_rdy, w_push, w_pop, w_empty;
   logic [7:0]    w_load_byte;

   // [0],[1] synchronize, [2] is history for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_scl_q <= '1;
         r_sda_q <= '1;
      end else begin
         r_scl_q <= {r_scl_q[1:0], bus.scl_i};
         r_sda_q <= {r_sda_q[1:0], bus.sda_i};
      end
   end

   assign w_scl   = r_scl_q[1];
   assign w_sda   = r_sda_q[1];
   assign w_rise  =  w_scl & ~r_scl_q[2];
   assign w_fall  = ~w_scl &  r_scl_q[2];
   assign w_start =  w_scl &  r_scl_q[2] & ~w_sda &  r_sda_q[2];
   assign w_stop  =  w_scl &  r_scl_q[2] &  w_sda & ~r_sda_q[2];

   assign w_empty     = (r_fcnt == '0);
   assign w_push      = bus.tx_vld_i & r_tx_rdy;
   assign w_fcnt_nxt  = r_fcnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
   assign w_load_byte = w_empty ? FILL_BYTE : r_mem[r_rp];

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wp] <= bus.tx_dat_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_fcnt   <= '0;
         r_tx_rdy <= 1'b1;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_fcnt   <= w_fcnt_nxt;
         r_tx_rdy <= (w_fcnt_nxt != (AW+1)'(TX_DEPTH));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_tx_sh   <= '1;
         r_rx_dat  <= '0;
         r_sda     <= 1'b1;
         r_rw      <= 1'b0;
         r_busy    <= 1'b0;
         r_rx_vld  <= 1'b0;
         r_start_o <= 1'b0;
         r_stop_o  <= 1'b0;
         r_unf     <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_sh      <= w_sh;
         r_tx_sh   <= w_tx_sh;
         r_rx_dat  <= w_rx_dat;
         r_sda     <= w_sda_o;
         r_rw      <= w_rw;
         r_busy    <= w_busy;
         r_rx_vld  <= w_rx_vld;
         r_start_o <= w_start_o;
         r_stop_o  <= w_stop_o;
         r_unf     <= w_unf;
      end
   end

   // sda_o only ever changes on a detected scl fall (or START/STOP/IGNORE release)
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_sh      = r_sh;
      w_tx_sh   = r_tx_sh;
      w_rx_dat  = r_rx_dat;
      w_sda_o   = r_sda;
      w_rw      = r_rw;
      w_busy    = r_busy;
      w_rx_vld  = 1'b0;
      w_start_o = 1'b0;
      w_stop_o  = 1'b0;
      w_unf     = 1'b0;
      w_pop     = 1'b0;
      if (w_stop) begin
         w_state  = IDLE;
         w_sda_o  = 1'b1;
         w_busy   = 1'b0;
         w_stop_o = 1'b1;
      end else if (w_start) begin
         w_state   = ADDR;
         w_cnt     = '0;
         w_sda_o   = 1'b1;
         w_start_o = 1'b1;
      end else begin
         case (r_state)
            ADDR: if (w_rise) begin
               w_sh  = {r_sh[5:0], w_sda};
               w_cnt = r_cnt + 4'd1;
               if (r_cnt == 4'd7) begin
                  if (r_sh == SLAVE_ADDR) begin
                     w_rw    = w_sda;
                     w_busy  = 1'b1;
                     w_state = ADDR_ACK;
                  end else begin
                     w_busy  = 1'b0;
                     w_state = IGNORE;
                  end
               end
            end
            ADDR_ACK, WR_ACK: begin
               if (w_fall) begin
                  w_sda_o = 1'b0;
               end else if (w_rise) begin
                  w_cnt = '0;
                  if (r_state == ADDR_ACK && r_rw) begin
                     w_tx_sh = w_load_byte;
                     w_pop   = ~w_empty;
                     w_unf   = w_empty;
                     w_state = RD_DATA;
                  end else begin
                     w_state = WR_DATA;
                  end
               end
            end
            WR_DATA: begin
               if (w_fall) begin
                  w_sda_o = 1'b1;
               end else if (w_rise) begin
                  w_sh  = {r_sh[5:0], w_sda};
                  w_cnt = r_cnt + 4'd1;
                  if (r_cnt == 4'd7) begin
                     w_rx_dat = {r_sh, w_sda};
                     w_rx_vld = 1'b1;
                     w_state  = WR_ACK;
                  end
               end
            end
            // the fall before the first rise drives the MSB; fall after the 8th releases
            RD_DATA: begin
               if (w_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_sda_o = 1'b1;
                     w_state = RD_ACK;
                  end else begin
                     w_sda_o = r_tx_sh[7];
                     w_tx_sh = {r_tx_sh[6:0], 1'b1};
                  end
               end else if (w_rise) begin
                  w_cnt = r_cnt + 4'd1;
               end
            end
            RD_ACK: if (w_rise) begin
               if (!w_sda) begin
                  w_tx_sh = w_load_byte;
                  w_pop   = ~w_empty;
                  w_unf   = w_empty;
                  w_cnt   = '0;
                  w_state = RD_DATA;
               end else begin
                  w_busy  = 1'b0;
                  w_state = IGNORE;
               end
            end
            IGNORE:  w_sda_o = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.sda_o       = r_sda;
   assign bus.tx_rdy_o    = r_tx_rdy;
   assign bus.rx_dat_o    = r_rx_dat;
   assign bus.rx_vld_o    = r_rx_vld;
   assign bus.start_o     = r_start_o;
   assign bus.stop_o      = r_stop_o;
   assign bus.rw_o        = r_rw;
   assign bus.busy_o      = r_busy;
   assign bus.underflow_o = r_unf;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master, transaction-level model of the target.
module tb_i2c_slave_responder;
   localparam int         HALF  = 12;
   localparam int         DEPTH = 8;
   localparam logic [7:0] FILL  = 8'hFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   i2c_slave_responder_if bus();
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   assign bus.scl_i = m_scl;
   assign bus.sda_i = m_sda & bus.sda_o;

   i2c_slave_responder #(.SLAVE_ADDR(7'h22), .TX_DEPTH(DEPTH), .FILL_BYTE(FILL)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   // model state
   logic [7:0] mq[$];
   logic [7:0] exp_rx[$];
   logic [7:0] rx_q[$];
   int exp_start = 0, exp_stop = 0, exp_unf = 0;
   int n_start = 0, n_stop = 0, n_unf = 0;

   // compare process state
   int          n_assert = 0, n_fail = 0;
   logic        chk_en = 1'b0;
   logic        exp_sda = 1'b1;
   string       pq_nm[$];
   logic [31:0] pq_act[$], pq_exp[$];
   string       c_nm;
   logic [31:0] c_act, c_exp;

   always @(negedge clk) begin
      if (chk_en) begin
         n_assert++;
         if (bus.sda_o !== exp_sda) begin
            n_fail++;
            $display("FAIL sda_o slot at %0t: got %b expected %b", $time, bus.sda_o, exp_sda);
         end
      end
      while (pq_nm.size() > 0) begin
         c_nm  = pq_nm.pop_front();
         c_act = pq_act.pop_front();
         c_exp = pq_exp.pop_front();
         n_assert++;
         if (c_act !== c_exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", c_nm, c_act, c_exp);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rx_vld_o)    rx_q.push_back(bus.rx_dat_o);
         if (bus.start_o)     n_start++;
         if (bus.stop_o)      n_stop++;
         if (bus.underflow_o) n_unf++;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      pq_nm.push_back(nm);
      pq_act.push_back(act);
      pq_exp.push_back(exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b);
      bus.tx_dat_i = b;
      bus.tx_vld_i = 1'b1;
      tick(1);
      bus.tx_vld_i = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(b);
   endtask

   task automatic model_pop(output logic [7:0] b);
      if (mq.size() > 0) b = mq.pop_front();
      else begin
         b = FILL;
         exp_unf++;
      end
   endtask

   function automatic bit addr_hit(input logic [7:0] a);
      return a[7:1] == 7'h22;
   endfunction

   task automatic start_cond();
      if (!m_scl) begin
         tick(HALF/2); m_sda = 1'b1;
         tick(HALF/2); m_scl = 1'b1;
         tick(HALF);
      end
      m_sda = 1'b0;
      tick(HALF); m_scl = 1'b0;
      exp_start++;
   endtask

   task automatic stop_cond();
      tick(HALF/2); m_sda = 1'b0;
      tick(HALF/2); m_scl = 1'b1;
      tick(HALF);   m_sda = 1'b1;
      tick(HALF);
      exp_stop++;
   endtask

   // one scl period; exp_s is what the target must drive while scl is high
   task automatic bit_slot(input bit drv, input bit exp_s, output bit seen);
      tick(HALF/2); m_sda = drv;
      tick(HALF/2); m_scl = 1'b1;
      tick(3);
      exp_sda = exp_s;
      chk_en  = 1'b1;
      tick(HALF-4);
      seen   = bus.sda_i;
      chk_en = 1'b0;
      tick(1);
      m_scl = 1'b0;
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit acked);
      bit v;
      for (int i = 7; i >= 0; i--) bit_slot(b[i], 1'b1, v);
      bit_slot(1'b1, !acked, v);
   endtask

   task automatic rd_byte(input bit m_ack, output logic [7:0] got);
      logic [7:0] e;
      bit v;
      model_pop(e);
      for (int i = 7; i >= 0; i--) begin
         bit_slot(1'b1, e[i], v);
         got[i] = v;
      end
      bit_slot(!m_ack, 1'b1, v);
      chk("rd_byte", got, e);
   endtask

   task automatic chk_rx(input string nm);
      chk({nm, " rx_count"}, rx_q.size(), exp_rx.size());
      foreach (exp_rx[i]) chk({nm, " rx_byte"}, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_rx[i]);
      chk({nm, " start_cnt"}, n_start, exp_start);
      chk({nm, " stop_cnt"}, n_stop, exp_stop);
      chk({nm, " unf_cnt"}, n_unf, exp_unf);
      rx_q.delete();
      exp_rx.delete();
   endtask

   initial begin
      logic [7:0] got, e;
      int u0, s0, p0;
      bit v;
      bus.tx_vld_i = 1'b0;
      bus.tx_dat_i = 8'h00;
      tick(4);
      chk("rst sda_o", bus.sda_o, 1);
      chk("rst tx_rdy", bus.tx_rdy_o, 1);
      chk("rst rx_dat", bus.rx_dat_o, 0);
      chk("rst rw", bus.rw_o, 0);
      chk("rst busy", bus.busy_o, 0);
      chk("rst strobes", {bus.rx_vld_o, bus.start_o, bus.stop_o, bus.underflow_o}, 0);
      rst = 1'b0;
      tick(4);

      // write 0x00..0x07
      start_cond();
      wr_byte(8'h44, addr_hit(8'h44));
      chk("T1 busy", bus.busy_o, 1);
      chk("T1 rw", bus.rw_o, 0);
      for (int i = 0; i < 8; i++) begin
         wr_byte(8'(i), 1'b1);
         exp_rx.push_back(8'(i));
      end
      chk("T1 rx7 literal", (rx_q.size() > 7) ? rx_q[7] : 8'hxx, 8'h07);
      stop_cond();
      chk("T1 busy after stop", bus.busy_o, 0);
      chk_rx("T1");

      // full read of 8 preloaded bytes, overflow push dropped
      for (int i = 8; i < 16; i++) push(8'(i));
      push(8'h55);
      tick(1);
      chk("T2 tx_rdy full", bus.tx_rdy_o, 0);
      u0 = n_unf;
      start_cond();
      wr_byte(8'h45, addr_hit(8'h45));
      chk("T2 rw", bus.rw_o, 1);
      chk("T2 busy", bus.busy_o, 1);
      for (int k = 0; k < 8; k++) begin
         rd_byte(k < 7, got);
         if (k == 0) chk("T2 first literal", got, 8'h08);
         if (k == 7) chk("T2 last literal", got, 8'h0F);
      end
      chk("T2 busy after NACK", bus.busy_o, 0);
      stop_cond();
      chk("T2 tx_rdy empty", bus.tx_rdy_o, 1);
      chk("T2 no underflow", n_unf - u0, 0);
      chk_rx("T2");

      // underflow: one queued byte, three read
      push(8'hA5);
      u0 = n_unf;
      start_cond();
      wr_byte(8'h45, 1'b1);
      rd_byte(1'b1, got); chk("T3 b0 literal", got, 8'hA5);
      rd_byte(1'b1, got); chk("T3 b1 literal", got, 8'hFF);
      rd_byte(1'b0, got);
      stop_cond();
      chk("T3 underflow pulses", n_unf - u0, 2);
      chk_rx("T3");

      // wrong address is NACKed and ignored
      start_cond();
      wr_byte(8'h46, addr_hit(8'h46));
      chk("T4 busy", bus.busy_o, 0);
      wr_byte(8'h12, 1'b0);
      stop_cond();
      chk_rx("T4");

      // write, repeated START, read
      s0 = n_start; p0 = n_stop;
      start_cond();
      wr_byte(8'h44, 1'b1);
      chk("T5 rw write", bus.rw_o, 0);
      wr_byte(8'h9C, 1'b1);
      exp_rx.push_back(8'h9C);
      start_cond();
      wr_byte(8'h45, 1'b1);
      chk("T5 rw read", bus.rw_o, 1);
      rd_byte(1'b0, got);
      stop_cond();
      chk("T5 start pulses", n_start - s0, 2);
      chk("T5 stop pulses", n_stop - p0, 1);
      chk_rx("T5");

      // reset in the middle of a read byte
      push(8'h81);
      push(8'h6C);
      start_cond();
      wr_byte(8'h45, 1'b1);
      rd_byte(1'b1, got);
      model_pop(e);
      for (int i = 7; i >= 5; i--) bit_slot(1'b1, e[i], v);
      tick(HALF);
      m_scl = 1'b1;
      tick(4);
      chk("T6 bit4 driven", bus.sda_o, e[4]);
      for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
      tick(1);
      chk("T6 tx_rdy full", bus.tx_rdy_o, 0);
      rst = 1'b1;
      tick(1);
      chk("T6 sda released", bus.sda_o, 1);
      chk("T6 tx_rdy", bus.tx_rdy_o, 1);
      rst = 1'b0;
      mq.delete();
      tick(4);
      start_cond();
      wr_byte(8'h44, 1'b1);
      wr_byte(8'h5A, 1'b1);
      exp_rx.push_back(8'h5A);
      stop_cond();
      start_cond();
      wr_byte(8'h45, 1'b1);
      rd_byte(1'b0, got);
      chk("T6 fifo flushed", got, 8'hFF);
      stop_cond();
      chk_rx("T6");

      tick(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
